matrix_wavefront_loader: RTL

- Producer side of the 3x3 systolic matrix multiplier.
- Accepts matrices A and B as an 18-beat byte stream under valid/ready and stores them.
- Drives the skewed 5-lane A and B wavefronts into the array, one wavefront step per STEP_CYCLES clocks, followed by zero drain steps while the array finishes.
- Pulses done when the multiplier's results are final.

---
 rtl/matrix_wavefront_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/matrix_wavefront_loader.sv
// ---------------------------------------------------------------------------
// matrix_wavefront_loader
//
// Producer side of a 3x3 systolic matrix multiplier. Collects A and B as an
// 18-beat byte stream (A row-major, then B row-major), then drives skewed
// 5-lane wavefronts into the array: three data steps, DRAIN_STEPS all-zero
// steps, and a one-cycle done pulse. Each step is held for STEP_CYCLES clocks.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst_n        synchronous active-low reset
//   s_valid      input beat valid
//   s_ready      loader can accept a beat (high only while loading)
//   s_data       element value
//   s_last       marks the final (18th) beat of a load
//   a_lane       A wavefront, lane l at bits [l*DW +: DW]
//   b_lane       B wavefront, same packing
//   step_strobe  one-cycle pulse on the first cycle of every step
//   step_idx     1-based step number, 0 when not stepping
//   busy         high while feeding or draining
//   done         one-cycle pulse after the last step
//   err          one-cycle pulse on a framing error
// ---------------------------------------------------------------------------
module matrix_wavefront_loader #(
    parameter int DW          = 8,
    parameter int STEP_CYCLES = 10,
    parameter int DRAIN_STEPS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    output logic [5*DW-1:0] a_lane,
    output logic [5*DW-1:0] b_lane,
    output logic            step_strobe,
    output logic [3:0]      step_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_CYCLES - 1);
    localparam logic [4:0] FINAL_STEP = 5'(3 + DRAIN_STEPS);

    logic [1:0]      state;
    logic [4:0]      beat_cnt;
    logic [7:0]      cyc_cnt;
    // One bit wider than step_idx so the final-step compare stays exact
    // for the largest drain length; step_idx shows the low four bits.
    logic [4:0]      step_cnt;

    logic [DW-1:0]   a_mem [9];
    logic [DW-1:0]   b_mem [9];

    logic            xfer;
    logic            step_end;
    logic [1:0]      next_s;
    logic [5*DW-1:0] next_a;
    logic [5*DW-1:0] next_b;

    // Row s of A enters lanes s..s+2; column s of B enters the same lanes.
    function automatic logic [3:0] a_index(input logic [1:0] s, input int l);
        return 4'(3 * int'(s) + l - int'(s));
    endfunction

    function automatic logic [3:0] b_index(input logic [1:0] s, input int l);
        return 4'(3 * (l - int'(s)) + int'(s));
    endfunction

    assign xfer     = s_valid && (state == ST_LOAD);
    assign step_end = (cyc_cnt == STEP_LAST);
    // 0-based index of the step about to start: step 0 when leaving LOAD,
    // otherwise the current 1-based count equals the next 0-based index.
    assign next_s   = (state == ST_LOAD) ? 2'd0 : step_cnt[1:0];

    always_comb begin
        next_a = '0;
        next_b = '0;
        for (int l = 0; l < 5; l++) begin
            if (next_s != 2'd3 && l >= int'(next_s) && l <= int'(next_s) + 2) begin
                next_a[l*DW +: DW] = a_mem[a_index(next_s, l)];
                next_b[l*DW +: DW] = b_mem[b_index(next_s, l)];
            end
        end
    end

    // Element storage: no reset, a discarded load is simply overwritten.
    always_ff @(posedge clk) begin
        if (xfer) begin
            if (beat_cnt < 5'd9)
                a_mem[beat_cnt[3:0]] <= s_data;
            else
                b_mem[4'(beat_cnt - 5'd9)] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            beat_cnt    <= '0;
            cyc_cnt     <= '0;
            step_cnt    <= '0;
            a_lane      <= '0;
            b_lane      <= '0;
            step_strobe <= 1'b0;
            err         <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            err         <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (xfer) begin
                        if (s_last && beat_cnt == 5'd17) begin
                            // Step 1 never uses b9, so every element it needs
                            // is already stored when the last beat arrives.
                            state       <= ST_FEED;
                            beat_cnt    <= '0;
                            cyc_cnt     <= '0;
                            step_cnt    <= 5'd1;
                            a_lane      <= next_a;
                            b_lane      <= next_b;
                            step_strobe <= 1'b1;
                        end else if (s_last || beat_cnt == 5'd17) begin
                            err      <= 1'b1;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 5'd1;
                        end
                    end
                end
                ST_FEED, ST_DRAIN: begin
                    if (step_end) begin
                        cyc_cnt <= '0;
                        if (step_cnt == FINAL_STEP) begin
                            state    <= ST_DONE;
                            step_cnt <= '0;
                            a_lane   <= '0;
                            b_lane   <= '0;
                        end else begin
                            step_cnt    <= step_cnt + 5'd1;
                            step_strobe <= 1'b1;
                            if (step_cnt < 5'd3) begin
                                state  <= ST_FEED;
                                a_lane <= next_a;
                                b_lane <= next_b;
                            end else begin
                                state  <= ST_DRAIN;
                                a_lane <= '0;
                                b_lane <= '0;
                            end
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_LOAD;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    assign s_ready  = (state == ST_LOAD);
    assign busy     = (state == ST_FEED) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign step_idx = step_cnt[3:0];

endmodule
